time_surface_memory: RTL and testbench

Event-driven time-surface store that sits between the DVS event decoder and the gesture classifier: accepts (x, y, polarity) events and increments a per-cell activity value, and answers the classifier's frame-scan read port. Each scan read returns a decayed value and writes that value back, so one full scan per frame applies one decay step to every cell. The memory is a 1R1W block RAM behind a 2-stage read-modify-write pipeline with hazard forwarding. The block self-clears after reset.

---
 rtl/ts_pkg.sv | 40 ++++
 rtl/ts_bram.sv | 22 ++
 rtl/time_surface_memory.sv | 154 +++++++++++++++
 tb/tb_time_surface_memory.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared types and arithmetic for the time-surface store: op encoding, grid
// geometry derivation and the saturating increment / decay rules.
package ts_pkg;

  localparam int MAX_VALUE_BITS = 16;

  typedef logic [MAX_VALUE_BITS:0] wide_t;

  typedef enum logic [1:0] {OP_NONE, OP_SCAN, OP_EVT} op_t;

  typedef enum logic {INIT, RUN} state_t;

  function automatic int num_cells(input int grid);
    return grid * grid;
  endfunction

  function automatic int coord_bits(input int grid);
    return $clog2(grid);
  endfunction

  function automatic int addr_bits(input int grid);
    return $clog2(grid * grid);
  endfunction

  // Widened by one bit so v + inc cannot wrap before the clamp.
  function automatic wide_t sat_inc(input wide_t v, input wide_t inc, input wide_t vmax);
    wide_t s;
    s = v + inc;
    return (s > vmax) ? vmax : s;
  endfunction

  // Every non-zero cell loses at least one count per scan so it reaches 0.
  function automatic wide_t decay_step(input wide_t v, input int shift);
    wide_t d;
    d = v >> shift;
    if (d == '0 && v != '0) d = wide_t'(1);
    return v - d;
  endfunction

endpackage

// File: rtl/ts_bram.sv
// Simple dual-port cell store: registered read, old data on read-during-write.
module ts_bram #(
  parameter int DEPTH     = 256,
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[raddr];
  end

endmodule

// File: rtl/time_surface_memory.sv
// Event-driven time surface: events add EVT_INC to a cell, scan reads decay and write back.
// Scan read latency 2 cycles; scans win arbitration so evt_ready drops while ts_read_enable is high.
module time_surface_memory
  import ts_pkg::*;
#(
  parameter int GRID_SIZE   = 16,
  parameter int VALUE_BITS  = 8,
  parameter int EVT_INC     = 16,
  parameter int DECAY_SHIFT = 3,
  parameter int ON_ONLY     = 0,
  localparam int COORD_BITS = coord_bits(GRID_SIZE),
  localparam int ADDR_BITS  = addr_bits(GRID_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  evt_valid,
  output logic                  evt_ready,
  input  logic [COORD_BITS-1:0] evt_x,
  input  logic [COORD_BITS-1:0] evt_y,
  input  logic                  evt_polarity,
  input  logic [ADDR_BITS-1:0]  ts_read_addr,
  input  logic                  ts_read_enable,
  output logic [VALUE_BITS-1:0] ts_read_value,
  output logic                  init_done,
  output logic [15:0]           debug_evt_count
);

  localparam int    NUM_CELLS   = num_cells(GRID_SIZE);
  localparam wide_t VALUE_MAX_W = wide_t'((1 << VALUE_BITS) - 1);
  localparam wide_t EVT_INC_W   = wide_t'(EVT_INC);

  state_t                state, state_next;
  logic [ADDR_BITS-1:0]  init_cnt;
  logic                  init_last;

  op_t                   issue_op;
  logic [ADDR_BITS-1:0]  issue_addr;
  logic [ADDR_BITS-1:0]  evt_cell;
  logic                  evt_discard;

  op_t                   s1_op, s2_op;
  logic [ADDR_BITS-1:0]  s1_addr, s2_addr, s3_addr;
  logic [VALUE_BITS-1:0] s2_data, s3_data;
  logic                  s3_vld;
  logic [VALUE_BITS-1:0] s1_raw, s1_res;
  wide_t                 s1_wide;

  logic                  ram_we;
  logic [ADDR_BITS-1:0]  ram_waddr;
  logic [VALUE_BITS-1:0] ram_wdata;
  logic [VALUE_BITS-1:0] ram_rd_data;

  // Power-of-two grid: y*GRID_SIZE + x is a plain concatenation.
  assign evt_cell    = {evt_y, evt_x};
  assign evt_discard = (ON_ONLY != 0) && !evt_polarity;
  assign init_last   = (init_cnt == ADDR_BITS'(NUM_CELLS - 1));

  always_comb begin
    state_next = state;
    evt_ready  = 1'b0;
    issue_op   = OP_NONE;
    issue_addr = ts_read_addr;
    unique case (state)
      INIT: begin
        if (init_last) state_next = RUN;
      end
      RUN: begin
        evt_ready = !ts_read_enable;
        if (ts_read_enable) begin
          issue_op = OP_SCAN;
        end else if (evt_valid && !evt_discard) begin
          issue_op   = OP_EVT;
          issue_addr = evt_cell;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= (state_next == RUN);
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // s2 holds the write about to land, s3 the one that just landed and is
  // still invisible to a read issued on that same edge.
  always_comb begin
    s1_raw = ram_rd_data;
    if (s3_vld && s3_addr == s1_addr) s1_raw = s3_data;
    if (s2_op != OP_NONE && s2_addr == s1_addr) s1_raw = s2_data;
  end

  assign s1_wide = wide_t'(s1_raw);
  assign s1_res  = VALUE_BITS'((s1_op == OP_SCAN) ? decay_step(s1_wide, DECAY_SHIFT)
                                                  : sat_inc(s1_wide, EVT_INC_W, VALUE_MAX_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op           <= OP_NONE;
      s1_addr         <= '0;
      s2_op           <= OP_NONE;
      s2_addr         <= '0;
      s2_data         <= '0;
      s3_vld          <= 1'b0;
      s3_addr         <= '0;
      s3_data         <= '0;
      ts_read_value   <= '0;
      debug_evt_count <= '0;
    end else begin
      s1_op   <= issue_op;
      s1_addr <= issue_addr;
      s2_op   <= s1_op;
      s2_addr <= s1_addr;
      s2_data <= s1_res;
      s3_vld  <= (s2_op != OP_NONE);
      s3_addr <= s2_addr;
      s3_data <= s2_data;
      if (s2_op == OP_SCAN) ts_read_value <= s2_data;
      if (s2_op == OP_EVT) debug_evt_count <= debug_evt_count + 16'd1;
    end
  end

  always_comb begin
    ram_we    = (s2_op != OP_NONE);
    ram_waddr = s2_addr;
    ram_wdata = s2_data;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt;
      ram_wdata = '0;
    end
  end

  ts_bram #(
    .DEPTH    (NUM_CELLS),
    .WIDTH    (VALUE_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_bram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .raddr  (issue_addr),
    .rd_data(ram_rd_data)
  );

endmodule

// File: tb/tb_time_surface_memory.sv
// Bench for time_surface_memory: two instances (ON_ONLY 0 and 1) share stimulus and
// are compared every cycle against an atomic-update reference model with 2-cycle result delay.
module tb_time_surface_memory;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       evt_valid = 1'b0;
  logic [3:0] evt_x = '0;
  logic [3:0] evt_y = '0;
  logic       evt_polarity = 1'b0;
  logic [7:0] ts_read_addr = '0;
  logic       ts_read_enable = 1'b0;

  logic        rdy0, rdy1, done0, done1;
  logic [7:0]  rv0, rv1;
  logic [15:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_surface_memory #(.GRID_SIZE(16), .VALUE_BITS(8), .EVT_INC(16), .DECAY_SHIFT(3), .ON_ONLY(0)) dut (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_ready(rdy0), .evt_x(evt_x), .evt_y(evt_y),
    .evt_polarity(evt_polarity), .ts_read_addr(ts_read_addr), .ts_read_enable(ts_read_enable),
    .ts_read_value(rv0), .init_done(done0), .debug_evt_count(cnt0));

  time_surface_memory #(.GRID_SIZE(16), .VALUE_BITS(8), .EVT_INC(16), .DECAY_SHIFT(3), .ON_ONLY(1)) dut_on (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_ready(rdy1), .evt_x(evt_x), .evt_y(evt_y),
    .evt_polarity(evt_polarity), .ts_read_addr(ts_read_addr), .ts_read_enable(ts_read_enable),
    .ts_read_value(rv1), .init_done(done1), .debug_evt_count(cnt1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory updates take effect at the issue edge; visible
  // results (scan value, event count) appear two edges later.
  typedef struct {
    bit scan;
    int d0;
    int d1;
    bit e0;
    bit e1;
  } mop_t;

  int   mem0 [256];
  int   mem1 [256];
  mop_t idle_op;
  mop_t p1, p2;
  bit   m_run = 1'b0;
  int   m_init = 0;
  int   m_rv0 = 0, m_rv1 = 0, m_cnt0 = 0, m_cnt1 = 0;

  function automatic int decay(input int v);
    int d = v / 8;
    if (v != 0 && d == 0) d = 1;
    return v - d;
  endfunction

  function automatic int bump(input int v);
    return (v + 16 > 255) ? 255 : v + 16;
  endfunction

  always @(posedge clk) begin : model
    int a;
    if (!rst_n) begin
      m_run = 1'b0; m_init = 0; p1 = idle_op; p2 = idle_op;
      m_rv0 = 0; m_rv1 = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      if (p2.scan) begin m_rv0 = p2.d0; m_rv1 = p2.d1; end
      if (p2.e0) m_cnt0 = (m_cnt0 + 1) % 65536;
      if (p2.e1) m_cnt1 = (m_cnt1 + 1) % 65536;
      p2 = p1;
      p1 = idle_op;
      if (!m_run) begin
        if (m_init == 255) begin
          m_run = 1'b1;
          for (int i = 0; i < 256; i++) begin mem0[i] = 0; mem1[i] = 0; end
        end else begin
          m_init++;
        end
      end else if (ts_read_enable) begin
        a = int'(ts_read_addr);
        mem0[a] = decay(mem0[a]);
        mem1[a] = decay(mem1[a]);
        p1.scan = 1'b1; p1.d0 = mem0[a]; p1.d1 = mem1[a];
      end else if (evt_valid) begin
        a = int'(evt_y) * 16 + int'(evt_x);
        mem0[a] = bump(mem0[a]);
        p1.e0 = 1'b1;
        if (evt_polarity) begin mem1[a] = bump(mem1[a]); p1.e1 = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit live;
    live = rst_n;
    chk("read_value",      int'(rv0),   live ? m_rv0 : 0);
    chk("read_value_on",   int'(rv1),   live ? m_rv1 : 0);
    chk("evt_ready",       int'(rdy0),  live ? int'(m_run && !ts_read_enable) : 0);
    chk("evt_ready_on",    int'(rdy1),  live ? int'(m_run && !ts_read_enable) : 0);
    chk("init_done",       int'(done0), live ? int'(m_run) : 0);
    chk("init_done_on",    int'(done1), live ? int'(m_run) : 0);
    chk("evt_count",       int'(cnt0),  live ? m_cnt0 : 0);
    chk("evt_count_on",    int'(cnt1),  live ? m_cnt1 : 0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    int n = 0;
    evt_valid = 1'b0; ts_read_enable = 1'b0; rst_n = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    while (!done0 && n < 400) begin @(negedge clk); n++; end
    chk("init_wait", int'(done0), 1);
    step();
  endtask

  task automatic scan_cell(input int a, output int v0, output int v1);
    ts_read_addr = 8'(a); ts_read_enable = 1'b1;
    step();
    ts_read_enable = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    v0 = int'(rv0); v1 = int'(rv1);
  endtask

  task automatic full_scan();
    ts_read_enable = 1'b1;
    for (int a = 0; a < 256; a++) begin ts_read_addr = 8'(a); step(); end
    ts_read_enable = 1'b0;
    step(); step(); step();
  endtask

  task automatic send_event(input int x, input int y, input bit pol);
    int n = 0;
    evt_x = 4'(x); evt_y = 4'(y); evt_polarity = pol; evt_valid = 1'b1;
    @(negedge clk);
    while (!rdy0 && n < 400) begin @(negedge clk); n++; end
    chk("evt_handshake", int'(rdy0), 1);
    step();
    evt_valid = 1'b0;
  endtask

  initial begin : main
    int v0, v1;
    bit saw, acc;
    #1 rst_n = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    repeat (255) @(posedge clk);
    @(negedge clk); chk("init_done_edge255", int'(done0), 0);
    @(posedge clk);
    @(negedge clk); chk("init_done_edge256", int'(done0), 1);
    step();
    full_scan();

    send_event(3, 2, 1'b1);
    scan_cell(35, v0, v1);
    chk("cell35_first", v0, 14);
    chk("cell35_first_on", v1, 14);
    scan_cell(35, v0, v1);
    chk("cell35_second", v0, 13);
    step();
    full_scan();

    do_reset();
    evt_x = 4'd0; evt_y = 4'd0; evt_polarity = 1'b1; evt_valid = 1'b1;
    repeat (20) step();
    evt_valid = 1'b0;
    step(); step(); step();
    chk("count_after_20", int'(cnt0), 20);
    scan_cell(0, v0, v1);
    chk("saturated_cell0", v0, 224);

    step();
    evt_x = 4'd5; evt_y = 4'd0; evt_valid = 1'b1;
    step();
    evt_valid = 1'b0;
    scan_cell(5, v0, v1);
    chk("forward_next_cycle", v0, 14);
    step();
    evt_valid = 1'b1;
    step();
    evt_valid = 1'b0;
    step();
    scan_cell(5, v0, v1);
    chk("forward_two_cycles", v0, 27);

    step();
    saw = 1'b0;
    evt_x = 4'd7; evt_y = 4'd7; evt_polarity = 1'b1; evt_valid = 1'b1; ts_read_enable = 1'b1;
    for (int a = 0; a < 256; a++) begin
      ts_read_addr = 8'(a);
      @(negedge clk);
      if (rdy0) saw = 1'b1;
      step();
    end
    ts_read_enable = 1'b0;
    chk("ready_low_during_scan", int'(saw), 0);
    @(negedge clk);
    chk("ready_after_scan", int'(rdy0), 1);
    step();
    evt_valid = 1'b0;
    step(); step(); step();
    chk("count_after_held_evt", int'(cnt0), 23);
    scan_cell(119, v0, v1);
    chk("held_evt_cell", v0, 14);

    step();
    send_event(4, 4, 1'b0);
    step(); step(); step();
    chk("count_off_evt", int'(cnt0), 24);
    chk("count_off_evt_on", int'(cnt1), 23);
    scan_cell(68, v0, v1);
    chk("off_evt_cell", v0, 14);
    chk("off_evt_cell_on", v1, 0);

    step();
    acc = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (!evt_valid || acc) begin
        evt_valid    = ($urandom_range(0, 1) == 1);
        evt_x        = 4'($urandom_range(0, 3));
        evt_y        = 4'($urandom_range(0, 1));
        evt_polarity = 1'($urandom_range(0, 1));
      end
      ts_read_enable = ($urandom_range(0, 2) == 0);
      ts_read_addr   = 8'($urandom_range(0, 1) * 16 + $urandom_range(0, 3));
      acc = evt_valid && !ts_read_enable;
      step();
    end
    evt_valid = 1'b0; ts_read_enable = 1'b0;
    step(); step(); step();

    ts_read_enable = 1'b1;
    for (int a = 0; a < 100; a++) begin ts_read_addr = 8'(a); step(); end
    rst_n = 1'b0;
    step();
    do_reset();
    chk("count_after_reset", int'(cnt0), 0);
    scan_cell(0, v0, v1);
    chk("cell0_after_reset", v0, 0);
    step();
    full_scan();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
